dm_lsu: RTL and testbench
=========================

Name: dm_lsu

Overview:
Data-memory stage load/store unit that consumes the EX/DM pipeline register outputs. It issues one data-bus transaction per memory instruction and formats store byte-lanes. It sign/zero-extends load data for writeback and stalls the pipeline while the access is outstanding. It sits between the EX/DM register and the DM/WB register and drives the core's data-bus master port.

Parameters:
ADDR_W, 32, byte address width; the data path is fixed at 32 bits.
TIMEOUT, 0, cycle limit spent in REQ+WAIT before an access fault; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
m_valid  in  1  instruction present in DM stage
m_mem_read  in  1  load
m_mem_write  in  1  store
m_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
m_alu_y  in  ADDR_W  effective byte address
m_rrd2  in  32  store data
mem_hold  in  1  downstream hold; the DM/WB stage cannot accept a result this cycle
dmem_req  out  1  bus request
dmem_we  out  1  write enable
dmem_addr  out  ADDR_W  word-aligned address ({m_alu_y[ADDR_W-1:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  response; one per granted request, for loads and stores
dmem_rdata  in  32  read data
dmem_err  in  1  bus error, qualified by rvalid
m_load_data  out  32  extended load result
lsu_stall  out  1  hold IF..EX/DM
lsu_exc  out  1  misaligned, illegal funct3, bus error or timeout
lsu_exc_cause  out  2  0 misaligned, 1 illegal funct3, 2 bus error, 3 timeout

Behaviour:
- acc = m_valid & (m_mem_read | m_mem_write); both flags set is treated as a load.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. Illegal: funct3 in {011,110,111}.
- A misaligned or illegal access issues no request: lsu_exc=1 combinationally while in IDLE with cause set, and lsu_stall=0.
- FSM states IDLE, REQ, WAIT, DONE. Reset (async, reset=0) forces IDLE, the counter to 0, the data/exc hold registers to 0, and all outputs to 0.
- IDLE: on an aligned acc, dmem_req=1 and lsu_stall=1.
  - gnt=1 -> WAIT.
  - gnt=0 -> REQ.
- REQ: dmem_req=1 with addr/we/be/wdata held stable from the live inputs. The upstream stall guarantees those inputs are stable. gnt -> WAIT. lsu_stall=1.
- WAIT: dmem_req=0, lsu_stall=1. On rvalid, capture the formatted load data (0 for stores) and any err into registers, then -> DONE. rvalid arriving in the same cycle as gnt is not legal; one cycle minimum separates them.
- DONE: lsu_stall=0, m_load_data and the registered lsu_exc/cause are driven.
  - !mem_hold -> IDLE; the EX/DM register advances on this edge.
  - mem_hold=1 -> stay in DONE. No re-issue occurs and the outputs stay stable.
- Timeout: the counter increments each cycle in REQ/WAIT and clears on entering IDLE. When TIMEOUT>0 and the count reaches TIMEOUT-1 without completion -> DONE with cause 3 and load data 0. A late rvalid is then ignored.
- Store lanes:
  - SB: wdata={4{b}}, be=0001<<addr[1:0].
  - SH: wdata={2{h}}, be=0011 when addr[1]=0, otherwise 1100.
  - SW: be=1111.
  - be=1111 for loads; dmem_we=0 for loads.
- Load extraction: select the byte by addr[1:0] and the half by addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
- m_load_data=0 in every state except DONE.
- Minimum access latency is 3 cycles (IDLE, WAIT, DONE) with 2 stall cycles.
- Reset mid-transaction abandons the access. The bus slave must tolerate a dropped req.

Test Plan:
1. LB at addr 0x103, rdata=0x80AA_BBCC, gnt in cycle 0, rvalid in cycle 1 -> stall high for 2 cycles; DONE m_load_data=0xFFFF_FF80.
2. LHU at 0x102, rdata=0x8001_1234 -> m_load_data=0x0000_8001, dmem_be=1111, dmem_addr=0x100.
3. SB 0x5A at 0x201 and SH 0xBEEF at 0x202 -> first dmem_be=0010, wdata=0x5A5A_5A5A; second dmem_be=1100, wdata=0xBEEF_BEEF, we=1.
4. LW at 0x106 -> no req, lsu_exc=1, cause 0, stall 0. Then funct3=011 -> cause 1.
5. gnt withheld 3 cycles, then rvalid with err=1 and mem_hold=1 for 2 cycles -> req and addr stable through REQ; DONE held 3 cycles; cause 2; exactly one request issued.
6. TIMEOUT=8 with no gnt -> DONE after 8 stall cycles with cause 3. Separately, reset driven low in WAIT -> all outputs 0 on the same edge and the FSM in IDLE.

Source files
------------

// File: rtl/dm_lsu.sv
// Data-memory stage load/store unit: issues one bus access per memory instruction,
// formats store lanes, extends load data and stalls the pipeline while the access is open.
module dm_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic              m_mem_read,
    input  logic              m_mem_write,
    input  logic [2:0]        m_funct3,
    input  logic [ADDR_W-1:0] m_alu_y,
    input  logic [31:0]       m_rrd2,
    input  logic              mem_hold,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_err,
    output logic [31:0]       m_load_data,
    output logic              lsu_stall,
    output logic              lsu_exc,
    output logic [1:0]        lsu_exc_cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam bit          TO_EN  = (TIMEOUT > 0);
    localparam logic [31:0] TO_LIM = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state_r;
    logic [31:0] cnt_r;
    logic [31:0] load_r;
    logic        exc_r;
    logic [1:0]  cause_r;

    logic        acc_s;
    logic        store_s;
    logic        illegal_s;
    logic        misal_s;
    logic        fault_s;
    logic        go_s;
    logic        timeout_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {a, 3'b000});
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return d;
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    // Decode access kind, alignment and legality of the DM-stage instruction.
    always_comb begin
        acc_s     = m_valid & (m_mem_read | m_mem_write);
        store_s   = m_mem_write & ~m_mem_read;
        illegal_s = 1'b0;
        misal_s   = 1'b0;
        case (m_funct3)
            3'b000, 3'b100: misal_s = 1'b0;
            3'b001, 3'b101: misal_s = m_alu_y[0];
            3'b010:         misal_s = |m_alu_y[1:0];
            default:        illegal_s = 1'b1;
        endcase
        fault_s   = acc_s & (illegal_s | misal_s);
        go_s      = reset & acc_s & ~fault_s;
        timeout_s = TO_EN & (cnt_r >= TO_LIM);
    end

    // Byte-enable and lane-replicated write data for stores; loads read the full word.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = 32'd0;
        if (store_s) begin
            case (m_funct3[1:0])
                2'b00: begin
                    be_s    = 4'b0001 << m_alu_y[1:0];
                    wdata_s = {4{m_rrd2[7:0]}};
                end
                2'b01: begin
                    be_s    = m_alu_y[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{m_rrd2[15:0]}};
                end
                default: begin
                    be_s    = 4'b1111;
                    wdata_s = m_rrd2;
                end
            endcase
        end else begin
            be_s    = 4'b1111;
            wdata_s = 32'd0;
        end
    end

    // Bus, stall and result outputs; everything reads as zero while reset is held.
    always_comb begin
        dmem_req      = reset & (((state_r == S_IDLE) & go_s) | (state_r == S_REQ));
        lsu_stall     = reset & (((state_r == S_IDLE) & go_s) | (state_r == S_REQ) |
                                 (state_r == S_WAIT));
        dmem_we       = reset & acc_s & store_s;
        dmem_addr     = reset ? {m_alu_y[ADDR_W-1:2], 2'b00} : {ADDR_W{1'b0}};
        dmem_be       = reset ? be_s : 4'd0;
        dmem_wdata    = reset ? wdata_s : 32'd0;
        m_load_data   = 32'd0;
        lsu_exc       = 1'b0;
        lsu_exc_cause = 2'd0;
        if (state_r == S_DONE) begin
            m_load_data   = load_r;
            lsu_exc       = exc_r;
            lsu_exc_cause = cause_r;
        end else if (reset && (state_r == S_IDLE) && fault_s) begin
            lsu_exc       = 1'b1;
            lsu_exc_cause = illegal_s ? 2'd1 : 2'd0;
        end else begin
            lsu_exc       = 1'b0;
            lsu_exc_cause = 2'd0;
        end
    end

    // Access FSM; the counter tracks stalled cycles of the access, issue cycle included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            cnt_r   <= 32'd0;
            load_r  <= 32'd0;
            exc_r   <= 1'b0;
            cause_r <= 2'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    load_r  <= 32'd0;
                    exc_r   <= 1'b0;
                    cause_r <= 2'd0;
                    if (go_s) begin
                        cnt_r   <= 32'd1;
                        state_r <= dmem_gnt ? S_WAIT : S_REQ;
                    end else begin
                        cnt_r <= 32'd0;
                    end
                end
                S_REQ: begin
                    if (timeout_s) begin
                        state_r <= S_DONE;
                        load_r  <= 32'd0;
                        exc_r   <= 1'b1;
                        cause_r <= 2'd3;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                        if (dmem_gnt) begin
                            state_r <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        state_r <= S_DONE;
                        load_r  <= store_s ? 32'd0 : fmt_load(m_funct3, m_alu_y[1:0], dmem_rdata);
                        exc_r   <= dmem_err;
                        cause_r <= dmem_err ? 2'd2 : 2'd0;
                    end else if (timeout_s) begin
                        state_r <= S_DONE;
                        load_r  <= 32'd0;
                        exc_r   <= 1'b1;
                        cause_r <= 2'd3;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                S_DONE: begin
                    if (!mem_hold) begin
                        state_r <= S_IDLE;
                        cnt_r   <= 32'd0;
                        load_r  <= 32'd0;
                        exc_r   <= 1'b0;
                        cause_r <= 2'd0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    cnt_r   <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// Directed and randomized bench for dm_lsu against a behavioural model of the
// access protocol, store lane formatting and load extension.
module tb_dm_lsu;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_mem_read, m_mem_write;
    logic [2:0]  m_funct3;
    logic [31:0] m_alu_y, m_rrd2;
    logic        mem_hold;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0] dmem_rdata;
    logic [31:0] m_load_data;
    logic        lsu_stall, lsu_exc;
    logic [1:0]  lsu_exc_cause;

    int total = 0;
    int bad   = 0;

    dm_lsu #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
        .m_funct3(m_funct3), .m_alu_y(m_alu_y), .m_rrd2(m_rrd2), .mem_hold(mem_hold),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .dmem_err(dmem_err), .m_load_data(m_load_data),
        .lsu_stall(lsu_stall), .lsu_exc(lsu_exc), .lsu_exc_cause(lsu_exc_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load value: pick the addressed byte/half arithmetically and sign-extend by range.
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
        longint v;
        int     sh;
        case (f3)
            3'b000, 3'b100: begin
                sh = 8 * int'(a[1:0]);
                v  = longint'((d >> sh) & 32'hFF);
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                sh = 16 * int'(a[1]);
                v  = longint'((d >> sh) & 32'hFFFF);
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(d);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz, b;
        if (!st) return 4'hF;
        sz = 1 << int'(f3[1:0]);
        b  = ((1 << sz) - 1) << int'(a[1:0]);
        return 4'(b);
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {24'd0, d[7:0]} * 32'h0101_0101;
            2'b01:   return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // One access: gnt after gd cycles, rvalid rdl cycles later, DONE held for hold cycles.
    // gd > 50 means the grant never comes and the access must time out.
    task automatic run_acc(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd, input int gd,
                           input int rdl, input bit er, input int hold,
                           input logic [31:0] exp_ld, input string tag);
        int c, stalls, grants;
        bit done, to;
        to = (gd > 50);
        @(posedge clk); #1;
        m_valid = 1'b1; m_mem_read = !st; m_mem_write = st; m_funct3 = f3;
        m_alu_y = a; m_rrd2 = sd; dmem_rdata = rd; mem_hold = (hold > 0);
        c = 0; stalls = 0; grants = 0; done = 1'b0;
        while (!done && c < 40) begin
            dmem_gnt    = (c == gd);
            dmem_rvalid = !to && (c == gd + rdl);
            dmem_err    = er && dmem_rvalid;
            @(negedge clk);
            if (lsu_stall) begin
                stalls++;
                if (dmem_req && dmem_gnt) grants++;
                if (c <= gd) begin
                    chk({tag, "_req"}, dmem_req, 1);
                    chk({tag, "_addr"}, dmem_addr, a & 32'hFFFF_FFFC);
                    chk({tag, "_be"}, dmem_be, m_be(st, f3, a));
                    chk({tag, "_we"}, dmem_we, st);
                    if (st) chk({tag, "_wdata"}, dmem_wdata, m_wd(f3, sd));
                end else begin
                    chk({tag, "_req_wait"}, dmem_req, 0);
                end
            end else begin
                done = 1'b1;
            end
            if (!done) begin
                @(posedge clk); #1;
                c++;
            end
        end
        chk({tag, "_done_reached"}, done, 1);
        chk({tag, "_stalls"}, stalls, to ? TO : gd + rdl + 1);
        chk({tag, "_grants"}, grants, to ? 0 : 1);
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                mem_hold = (k < hold); dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0;
                @(negedge clk);
            end
            chk({tag, "_done_stall"}, lsu_stall, 0);
            chk({tag, "_done_req"}, dmem_req, 0);
            chk({tag, "_ld"}, m_load_data, to ? 32'd0 : exp_ld);
            chk({tag, "_exc"}, lsu_exc, to | er);
            chk({tag, "_cause"}, lsu_exc_cause, to ? 3 : (er ? 2 : 0));
        end
        @(posedge clk); #1;
        m_valid = 1'b0; m_mem_read = 1'b0; m_mem_write = 1'b0; mem_hold = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_ld"}, m_load_data, 0);
        chk({tag, "_idle_stall"}, lsu_stall, 0);
        chk({tag, "_idle_exc"}, lsu_exc, 0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, sd, rd;
        bit          st, er;
        int          sz;
        reset = 1'b0; m_valid = 1'b0; m_mem_read = 1'b0; m_mem_write = 1'b0;
        m_funct3 = 3'b000; m_alu_y = 32'd0; m_rrd2 = 32'd0; mem_hold = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0; dmem_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", lsu_stall, 0);
        chk("rst_ld", m_load_data, 0);
        chk("rst_exc", lsu_exc, 0);
        reset = 1'b1;

        run_acc(1'b0, 3'b000, 32'h103, 32'd0, 32'h80AA_BBCC, 0, 1, 1'b0, 0, 32'hFFFF_FF80, "lb");
        run_acc(1'b0, 3'b101, 32'h102, 32'd0, 32'h8001_1234, 0, 1, 1'b0, 0, 32'h0000_8001, "lhu");
        run_acc(1'b1, 3'b000, 32'h201, 32'h5A, 32'hDEAD_BEEF, 0, 1, 1'b0, 0, 32'd0, "sb");
        run_acc(1'b1, 3'b001, 32'h202, 32'hBEEF, 32'h1234_5678, 0, 1, 1'b0, 0, 32'd0, "sh");

        // Misaligned word load, then illegal funct3: no request, combinational fault.
        @(posedge clk); #1;
        m_valid = 1'b1; m_mem_read = 1'b1; m_funct3 = 3'b010; m_alu_y = 32'h106;
        @(negedge clk);
        chk("mis_req", dmem_req, 0);
        chk("mis_exc", lsu_exc, 1);
        chk("mis_cause", lsu_exc_cause, 0);
        chk("mis_stall", lsu_stall, 0);
        @(posedge clk); #1;
        m_funct3 = 3'b011; m_alu_y = 32'h104;
        @(negedge clk);
        chk("ill_req", dmem_req, 0);
        chk("ill_exc", lsu_exc, 1);
        chk("ill_cause", lsu_exc_cause, 1);
        @(posedge clk); #1;
        m_valid = 1'b0; m_mem_read = 1'b0;

        run_acc(1'b0, 3'b010, 32'h500, 32'd0, 32'h1234_5678, 3, 1, 1'b1, 2, 32'h1234_5678, "err");
        run_acc(1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 100, 1, 1'b0, 0, 32'd0, "tmo");

        // Reset asserted while the access waits for its response.
        @(posedge clk); #1;
        m_valid = 1'b1; m_mem_read = 1'b1; m_funct3 = 3'b010; m_alu_y = 32'h400; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        chk("rw_stall_pre", lsu_stall, 1);
        #1 reset = 1'b0;
        #1;
        chk("rw_req", dmem_req, 0);
        chk("rw_we", dmem_we, 0);
        chk("rw_addr", dmem_addr, 0);
        chk("rw_be", dmem_be, 0);
        chk("rw_wdata", dmem_wdata, 0);
        chk("rw_ld", m_load_data, 0);
        chk("rw_stall", lsu_stall, 0);
        chk("rw_exc", lsu_exc, 0);
        chk("rw_cause", lsu_exc_cause, 0);
        m_valid = 1'b0; m_mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_acc(1'b0, 3'b100, 32'h601, 32'd0, 32'hCAFE_F00D, 1, 2, 1'b0, 1, 32'h0000_00F0, "post_rst");

        for (int i = 0; i < 30; i++) begin
            st = ($urandom_range(0, 1) == 1);
            if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            sz = 1 << int'(f3[1:0]);
            a  = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3) & ~(sz - 1));
            sd = $urandom;
            rd = $urandom;
            er = ($urandom_range(0, 7) == 0);
            run_acc(st, f3, a, sd, rd, $urandom_range(0, 2), $urandom_range(1, 2), er,
                    $urandom_range(0, 2), st ? 32'd0 : m_load(f3, a, rd), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
